alu_muldiv_iter: RTL

//  Iterative RV32M multiply/divide unit; parametrised companion to the single-cycle ALU.

---
 rtl/alu_muldiv_iter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Iterative RV32M multiply/divide unit, one bit per cycle,
//               valid/ready handshake on both sides with a passthrough tag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int                 c_CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [1:0]         c_IDLE      = 2'd0;
    localparam logic [1:0]         c_CALC      = 2'd1;
    localparam logic [1:0]         c_DONE      = 2'd2;
    localparam logic [c_CNT_W-1:0] c_CNT_START = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   c_ONES      = {WIDTH{1'b1}};

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_out_tag;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_out_data;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;

    logic [WIDTH-1:0]   w_mul_add;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign w_accept = in_valid & in_ready & ~flush;

    // Operand signedness by funct3: divides are signed when funct3[0]=0,
    // multiplies treat rs1 as signed except MULHU and rs2 as signed for MUL/MULH.
    assign w_a_signed = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
    assign w_b_signed = in_op[2] ? ~in_op[0] : ~in_op[1];
    assign w_sign_a   = w_a_signed & in_rs1[WIDTH-1];
    assign w_sign_b   = w_b_signed & in_rs2[WIDTH-1];
    assign w_abs_a    = w_sign_a ? -in_rs1 : in_rs1;
    assign w_abs_b    = w_sign_b ? -in_rs2 : in_rs2;

    assign w_div_zero = in_op[2] & (in_rs2 == '0);
    assign w_div_ovf  = in_op[2] & ~in_op[0] & (in_rs1 == c_MIN_NEG) & (in_rs2 == c_ONES);
    assign w_special  = w_div_zero | w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = in_op[1] ? in_rs1 : c_ONES;
        end else if (w_div_ovf) begin
            w_special_res = in_op[1] ? '0 : in_rs1;
        end
    end

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_add  = r_acc[0] ? r_opnd : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_add};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: remainder in the high half, quotient shifts into the low half.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_step = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_quot = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = w_rem;
        case (r_op)
            3'b000:                 w_final = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_special ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (flush) begin
                    w_next_state = c_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (flush || out_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_IDLE:  in_ready  = 1'b1;
            c_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_tag      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op    <= in_op;
                        r_tag   <= in_tag;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        if (w_special) begin
                            r_out_data <= w_special_res;
                            r_out_tag  <= in_tag;
                        end else begin
                            r_cnt  <= c_CNT_START;
                            r_opnd <= in_op[2] ? w_abs_b : w_abs_a;
                            r_acc  <= in_op[2] ? {{WIDTH{1'b0}}, w_abs_a}
                                               : {{WIDTH{1'b0}}, w_abs_b};
                        end
                    end
                end
                c_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_ONE) begin
                        r_out_data <= w_final;
                        r_out_tag  <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_tag  = r_out_tag;

endmodule
`default_nettype wire
